// File: rtl/sm2_wordserial_mult.sv
// Word-serial 256x256 unsigned multiplier for the SM2 modular-multiply datapath.
// Scans b one W-bit word per cycle (LS word first) and accumulates a*word into a 512-bit product.
module sm2_wordserial_mult #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] product,
    output logic         busy
);

    localparam int unsigned N     = 256 / W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PP_W  = 256 + W;
    localparam int unsigned SH_W  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [255:0]       a_q;
    logic [255:0]       b_q;
    logic [511:0]       acc;

    logic               last_c;
    logic               accept_c;
    logic               step_c;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               busy_d;

    logic [SH_W-1:0]    shift_amt_c;
    logic [W-1:0]       b_word_c;
    logic [PP_W-1:0]    pp_c;
    logic [511:0]       pp_shifted_c;
    logic [511:0]       sum_c;

    assign last_c = (cnt == CNT_W'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = BUSY;
            BUSY: if (last_c)    state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Output/control decode; handshake flags are precomputed from the next state
    always_comb begin
        accept_c    = 1'b0;
        step_c      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        accept_c    = (state == IDLE) && in_valid;
        step_c      = (state == BUSY);
        in_ready_d  = (state_nxt == IDLE);
        out_valid_d = (state_nxt == DONE);
        busy_d      = (state_nxt == BUSY) || (state_nxt == DONE);
    end

    // Handshake flags registered so they are clean state decodes at the ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // One partial product per cycle, aligned to the word position of b being scanned
    always_comb begin
        shift_amt_c  = SH_W'(cnt) * SH_W'(W);
        b_word_c     = b_q[shift_amt_c +: W];
        pp_c         = PP_W'(a_q) * PP_W'(b_word_c);
        pp_shifted_c = 512'(pp_c) << shift_amt_c;
        sum_c        = acc + pp_shifted_c;
    end

    // Operand latch, word counter and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept_c) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
        end else if (step_c) begin
            acc <= sum_c;
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_sm2_wordserial_mult.sv
// Directed-vector and randomised bench for sm2_wordserial_mult (W=32).
module tb_sm2_wordserial_mult;

    localparam int unsigned W = 32;
    localparam int unsigned N = 256 / W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] a_in;
    logic [255:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] product;
    logic         busy;

    int checks;
    int failures;

    sm2_wordserial_mult #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] exp;
        int           hold;
        bit           pulse;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // One full transaction: accept, wait for the result, hold it for 'hold' cycles, then hand off
    task automatic do_mult(input string name, input logic [255:0] a, input logic [255:0] b,
                           input logic [511:0] exp, input int hold, input bit pulse);
        int           lat;
        int           waitc;
        logic [511:0] got;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({name, ".in_ready"}, 512'(in_ready), 512'(1));
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = rand256();
        b_in     = rand256();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({name, ".busy"}, 512'({busy, in_ready, out_valid}), 512'(3'b100));
            end
        end while (!out_valid && lat < 100);
        chk({name, ".latency"}, 512'(lat), 512'(N + 1));
        got = product;
        chk({name, ".product"}, got, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse && (h % 2 == 0);
            a_in     = rand256();
            @(negedge clk);
            chk({name, ".hold"}, product, got);
            chk({name, ".hold_flags"}, 512'({out_valid, in_ready, busy}), 512'(3'b101));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, ".release"}, 512'({out_valid, in_ready, busy}), 512'(3'b010));
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] p;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        ones      = '1;
        p         = 256'hfffffffe_ffffffff_ffffffff_ffffffff_ffffffff_00000000_ffffffff_ffffffff;

        vecs[0] = '{a: '0, b: '0, exp: '0, hold: 0, pulse: 1'b0};
        vecs[1] = '{a: ones, b: ones,
                    exp: {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, hold: 1, pulse: 1'b0};
        vecs[2] = '{a: p, b: 256'd2,
                    exp: {255'd0, 257'h1_fffffffd_ffffffff_ffffffff_ffffffff_fffffffe_00000001_ffffffff_fffffffe},
                    hold: 0, pulse: 1'b0};
        vecs[3] = '{a: 256'd3, b: 256'd5, exp: 512'd15, hold: 5, pulse: 1'b1};
        vecs[4] = '{a: ones, b: 256'd1, exp: {256'd0, ones}, hold: 0, pulse: 1'b0};
        vecs[5] = '{a: {1'b1, 255'd0}, b: {1'b1, 255'd0}, exp: {2'b01, 510'd0}, hold: 2, pulse: 1'b0};
        vecs[6] = '{a: 256'h1_0000_0001, b: {32'h1, 224'd0},
                    exp: {255'd0, 1'b1, 32'h1, 224'd0}, hold: 0, pulse: 1'b0};
        vecs[7] = '{a: 256'hffff_ffff, b: 256'hffff_ffff, exp: 512'hffff_fffe_0000_0001,
                    hold: 0, pulse: 1'b0};
        vecs[8] = '{a: 256'd123456789, b: 256'd987654321, exp: 512'd121932631112635269,
                    hold: 1, pulse: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.flags", 512'({in_ready, out_valid, busy}), 512'(3'b100));
        chk("reset.product", product, '0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp,
                    vecs[i].hold, vecs[i].pulse);
        end

        // Reset in the middle of BUSY aborts with no partial result
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = ones;
        b_in     = ones;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort.pre_busy", 512'(busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("abort.flags", 512'({in_ready, out_valid, busy}), 512'(3'b100));
        chk("abort.product", product, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mult("abort.after", 256'd3, 256'd5, 512'd15, 0, 1'b0);

        // Random operands with random hold times
        for (int r = 0; r < 30; r++) begin
            logic [255:0] ra;
            logic [255:0] rb;
            ra = rand256();
            rb = rand256();
            if (r == 0) ra = ones;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_mult($sformatf("rand%0d", r), ra, rb, 512'(ra) * 512'(rb),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
